// File: rtl/gen_frame_sequencer.sv
// gen_frame_sequencer
//   Frame-level controller in front of the generator streaming datapath.
//   Accepts FRAME_PIXELS source pixels over valid/ready and forwards them
//   (registered) to the generator. It then pushes FLUSH_PIXELS zero pixels
//   to drain the pipeline, collects the first OUT_PIXELS generator outputs
//   and tags the last one. Completion, drain timeout and frame count are
//   reported.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, abort                frame start (IDLE only), synchronous abort
//   src_valid/src_data/src_ready   upstream pixel handshake
//   gen_valid_in/gen_data_in    registered feed into the generator
//   gen_valid_out/gen_data_out  generator result stream
//   out_valid/out_data/out_last accepted output pixels, last tagged
//   busy, done                  state != IDLE, one-cycle end-of-frame pulse
//   err_timeout                 sticky drain timeout, cleared by next start
//   frame_cnt                   completed frames (timed-out ones included)
module gen_frame_sequencer #(
   parameter int DATA_WIDTH    = 16,
   parameter int FRAME_PIXELS  = 1024,
   parameter int FLUSH_PIXELS  = 200,
   parameter int OUT_PIXELS    = 1024,
   parameter int DRAIN_TIMEOUT = 4096,
   parameter int CNT_W         = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  src_valid,
   input  logic [DATA_WIDTH-1:0] src_data,
   output logic                  src_ready,
   output logic                  gen_valid_in,
   output logic [DATA_WIDTH-1:0] gen_data_in,
   input  logic                  gen_valid_out,
   input  logic [DATA_WIDTH-1:0] gen_data_out,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  err_timeout,
   output logic [15:0]           frame_cnt
);

   localparam logic [CNT_W-1:0] FRAME_C = CNT_W'(FRAME_PIXELS);
   localparam logic [CNT_W-1:0] FLUSH_C = CNT_W'(FLUSH_PIXELS);
   localparam logic [CNT_W-1:0] OUT_C   = CNT_W'(OUT_PIXELS);
   localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(DRAIN_TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FEED,
      S_FLUSH,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      in_cnt_q, in_cnt_d;
   logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
   logic [CNT_W-1:0]      idle_cnt_q, idle_cnt_d;
   logic                  err_timeout_q, err_timeout_d;
   logic [15:0]           frame_cnt_q, frame_cnt_d;
   logic                  gen_valid_in_q, gen_valid_in_d;
   logic [DATA_WIDTH-1:0] gen_data_in_q, gen_data_in_d;
   logic                  out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_last_q, out_last_d;

   logic xfer;
   logic out_active;

   assign xfer       = (state_q == S_FEED) && src_valid;
   assign out_active = (state_q == S_FEED) || (state_q == S_FLUSH) ||
                       (state_q == S_DRAIN);

   always_comb begin
      state_d        = state_q;
      in_cnt_d       = in_cnt_q;
      flush_cnt_d    = flush_cnt_q;
      out_cnt_d      = out_cnt_q;
      idle_cnt_d     = idle_cnt_q;
      err_timeout_d  = err_timeout_q;
      frame_cnt_d    = frame_cnt_q;
      gen_valid_in_d = 1'b0;
      gen_data_in_d  = gen_data_in_q;
      out_valid_d    = 1'b0;
      out_data_d     = out_data_q;
      out_last_d     = 1'b0;

      // Only the first OUT_PIXELS results of a frame are forwarded; later
      // ones are flush artefacts and are dropped.
      if (out_active && gen_valid_out && (out_cnt_q < OUT_C)) begin
         out_valid_d = 1'b1;
         out_data_d  = gen_data_out;
         out_cnt_d   = out_cnt_q + 1'b1;
         out_last_d  = ((out_cnt_q + 1'b1) == OUT_C);
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d       = S_FEED;
               in_cnt_d      = '0;
               flush_cnt_d   = '0;
               out_cnt_d     = '0;
               idle_cnt_d    = '0;
               err_timeout_d = 1'b0;
            end
         end
         S_FEED: begin
            if (xfer) begin
               gen_valid_in_d = 1'b1;
               gen_data_in_d  = src_data;
               in_cnt_d       = in_cnt_q + 1'b1;
               if ((in_cnt_q + 1'b1) == FRAME_C)
                  state_d = (FLUSH_PIXELS == 0) ? S_DRAIN : S_FLUSH;
            end
         end
         S_FLUSH: begin
            // The feed register trails the state by one cycle, so FLUSH
            // stays one cycle longer than the number of zeros it loads;
            // the last zero is on the bus in that extra cycle and DRAIN
            // starts with gen_valid_in low.
            if (flush_cnt_q < FLUSH_C) begin
               gen_valid_in_d = 1'b1;
               gen_data_in_d  = '0;
               flush_cnt_d    = flush_cnt_q + 1'b1;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_cnt_q == OUT_C) begin
               state_d = S_DONE;
            end else if (gen_valid_out) begin
               idle_cnt_d = '0;
            end else if ((idle_cnt_q + 1'b1) >= TMO_C) begin
               idle_cnt_d    = idle_cnt_q + 1'b1;
               err_timeout_d = 1'b1;
               state_d       = S_DONE;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over everything and leaves frame status untouched.
      if (abort) begin
         state_d        = S_IDLE;
         gen_valid_in_d = 1'b0;
         out_valid_d    = 1'b0;
         out_last_d     = 1'b0;
         frame_cnt_d    = frame_cnt_q;
         err_timeout_d  = err_timeout_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         in_cnt_q       <= '0;
         flush_cnt_q    <= '0;
         out_cnt_q      <= '0;
         idle_cnt_q     <= '0;
         err_timeout_q  <= 1'b0;
         frame_cnt_q    <= '0;
         gen_valid_in_q <= 1'b0;
         gen_data_in_q  <= '0;
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         out_last_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         in_cnt_q       <= in_cnt_d;
         flush_cnt_q    <= flush_cnt_d;
         out_cnt_q      <= out_cnt_d;
         idle_cnt_q     <= idle_cnt_d;
         err_timeout_q  <= err_timeout_d;
         frame_cnt_q    <= frame_cnt_d;
         gen_valid_in_q <= gen_valid_in_d;
         gen_data_in_q  <= gen_data_in_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         out_last_q     <= out_last_d;
      end
   end

   assign src_ready    = (state_q == S_FEED);
   assign gen_valid_in = gen_valid_in_q;
   assign gen_data_in  = gen_data_in_q;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_last     = out_last_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign err_timeout  = err_timeout_q;
   assign frame_cnt    = frame_cnt_q;

endmodule
